// File: rtl/sample_search_ctrl_if.sv
// sample_search_ctrl_if: control, checker and sample handshake bundle for the search sequencer
interface sample_search_ctrl_if #(
  parameter int CAND_W = 64,
  parameter int TRY_W  = 16
);
  logic              start;
  logic              seed_load;
  logic [CAND_W-1:0] seed;
  logic [TRY_W-1:0]  max_tries;
  logic [CAND_W-1:0] cand_data;
  logic              cand_valid;
  logic              chk_sat;
  logic [CAND_W-1:0] sample_data;
  logic              sample_valid;
  logic              sample_ready;
  logic              busy;
  logic              done;
  logic              fail;
  logic [TRY_W-1:0]  tries;
  modport master (
    input  start, seed_load, seed, max_tries, chk_sat, sample_ready,
    output cand_data, cand_valid, sample_data, sample_valid, busy, done, fail, tries
  );
  modport slave (
    output start, seed_load, seed, max_tries, chk_sat, sample_ready,
    input  cand_data, cand_valid, sample_data, sample_valid, busy, done, fail, tries
  );
endinterface

// File: rtl/sample_search_ctrl.sv
// sample_search_ctrl: LFSR candidate generator that searches for a vector satisfying an external checker
module sample_search_ctrl #(
  parameter int                CAND_W  = 64,
  parameter logic [CAND_W-1:0] POLY    = 64'hD800_0000_0000_0000,
  parameter int                CHK_LAT = 1,
  parameter int                TRY_W   = 16
) (
  input logic clk,
  input logic rst,
  sample_search_ctrl_if.master bus
);
  typedef enum logic [1:0] {IDLE, GEN, WAIT, HOLD} state_t;
  localparam logic [3:0] LAT = 4'(CHK_LAT);
  state_t            state;
  logic [CAND_W-1:0] lfsr;
  logic [CAND_W-1:0] seed_fix;
  logic [CAND_W-1:0] nxt;
  logic [3:0]        cnt;
  logic [TRY_W-1:0]  limit;
  logic [TRY_W-1:0]  tries_n;
  logic              done_r;
  logic              sample_pt;
  logic              give_up;
  logic              accept;
  function automatic logic [CAND_W-1:0] step(input logic [CAND_W-1:0] s);
    return (s >> 1) ^ (s[0] ? POLY : '0);
  endfunction
  // next candidate (a same-cycle seed load feeds the first step), decision point and handshake terms
  always_comb begin
    seed_fix  = (bus.seed == '0) ? CAND_W'(1) : bus.seed;
    nxt       = step((state == IDLE && bus.seed_load) ? seed_fix : lfsr);
    sample_pt = (state == GEN && LAT == 4'd0) || (state == WAIT && cnt == 4'd1);
    tries_n   = (&bus.tries) ? bus.tries : bus.tries + TRY_W'(1);
    give_up   = (limit != '0) && (tries_n == limit);
    accept    = (state == HOLD) && bus.sample_valid && bus.sample_ready;
  end
  // done covers both the registered give-up pulse and the live accept cycle; fail only ever rides the former
  assign bus.done = done_r | accept;
  assign bus.fail = done_r;
  // search sequencer: candidate issue, latency wait, decision and sample hold
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      lfsr             <= CAND_W'(1);
      cnt              <= '0;
      limit            <= '0;
      done_r           <= 1'b0;
      bus.cand_data    <= '0;
      bus.cand_valid   <= 1'b0;
      bus.sample_data  <= '0;
      bus.sample_valid <= 1'b0;
      bus.busy         <= 1'b0;
      bus.tries        <= '0;
    end else begin
      bus.cand_valid <= 1'b0;
      done_r         <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.seed_load) lfsr <= seed_fix;
          if (bus.start) begin
            bus.tries      <= '0;
            limit          <= bus.max_tries;
            bus.busy       <= 1'b1;
            lfsr           <= nxt;
            bus.cand_data  <= nxt;
            bus.cand_valid <= 1'b1;
            state          <= GEN;
          end
        end
        GEN, WAIT: begin
          cnt <= (state == GEN) ? LAT : cnt - 4'd1;
          if (state == GEN && LAT != 4'd0) state <= WAIT;
          if (sample_pt) begin
            if (bus.chk_sat) begin
              bus.sample_data  <= bus.cand_data;
              bus.sample_valid <= 1'b1;
              state            <= HOLD;
            end else begin
              bus.tries <= tries_n;
              if (give_up) begin
                done_r   <= 1'b1;
                bus.busy <= 1'b0;
                state    <= IDLE;
              end else begin
                lfsr           <= nxt;
                bus.cand_data  <= nxt;
                bus.cand_valid <= 1'b1;
                state          <= GEN;
              end
            end
          end
        end
        HOLD: begin
          if (accept) begin
            bus.sample_valid <= 1'b0;
            bus.busy         <= 1'b0;
            state            <= IDLE;
          end
        end
      endcase
    end
  end
endmodule
